// File: rtl/dfe_prl_ctrl.sv
// -----------------------------------------------------------------------------
// dfe_prl_ctrl
// Sequencer for the parallel DFE datapath. It holds a host-written
// pulse-response coefficient table and streams it into the DFE over the
// load_mem/location/mem_data port. It then waits for the DFE's done_wait and
// forwards the received symbol stream. Reload, abort, done_wait timeout and
// zero-tap0 errors are handled here.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cfg_wr_en/addr/data  coefficient table write ({mantissa, shift}); these
//                        writes take effect only in IDLE or ERROR
//   start, abort         command pulses (abort has priority)
//   sym_in[_valid]       received symbol stream
//   load_mem, location,  coefficient load port to the DFE (mem_data is
//   mem_data             zero-extended to 64 bits)
//   done_wait            DFE load-complete flag
//   dfe_signal_in[_valid] symbol stream to the DFE (one-cycle latency, RUN only)
//   busy, running        LOAD/WAIT_DONE and RUN indicators
//   error, err_code      sticky error flag; code 1 = tap0 mantissa zero,
//                        code 2 = done_wait timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module dfe_prl_ctrl #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int LOAD_PAD              = 2,
    parameter int DONE_TIMEOUT          = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_wr_en,
    input  logic [7:0]                          cfg_addr,
    input  logic [4*SIGNAL_RESOLUTION-1:0]      cfg_data,
    input  logic                                start,
    input  logic                                abort,
    input  logic signed [SIGNAL_RESOLUTION-1:0] sym_in,
    input  logic                                sym_in_valid,
    output logic                                load_mem,
    output logic [7:0]                          location,
    output logic [63:0]                         mem_data,
    input  logic                                done_wait,
    output logic signed [SIGNAL_RESOLUTION-1:0] dfe_signal_in,
    output logic                                dfe_signal_in_valid,
    output logic                                busy,
    output logic                                running,
    output logic                                error,
    output logic [1:0]                          err_code
);

    localparam int PRL      = PULSE_RESPONSE_LENGTH;
    localparam int SR       = SIGNAL_RESOLUTION;
    localparam int CW       = 4 * SR;
    localparam int LOAD_LEN = PRL + LOAD_PAD;
    localparam int WCW      = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t          state;
    logic [CW-1:0]   coef_tab [PRL];
    logic [15:0]     load_cnt;
    logic [WCW-1:0]  wait_cnt;

    logic            tap0_ok;
    logic            cfg_open;
    logic [15:0]     next_k;
    logic [CW-1:0]   next_word;

    // Load cycles past the last tap (the pad) keep presenting the last tap,
    // so the DFE's lagging write address still sees stable data.
    function automatic logic [7:0] tap_loc(input logic [15:0] k);
        if (k >= 16'(PRL))
            return 8'(PRL - 1);
        return k[7:0];
    endfunction

    assign tap0_ok  = (coef_tab[0][CW-1:2*SR] != '0);
    assign cfg_open = (state == S_IDLE) || (state == S_ERROR);

    always_comb begin
        next_k    = load_cnt + 16'd1;
        next_word = '0;
        for (int i = 0; i < PRL; i++) begin
            if (tap_loc(next_k) == 8'(i))
                next_word = coef_tab[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            load_cnt            <= '0;
            wait_cnt            <= '0;
            load_mem            <= 1'b0;
            location            <= '0;
            mem_data            <= '0;
            dfe_signal_in       <= '0;
            dfe_signal_in_valid <= 1'b0;
            busy                <= 1'b0;
            running             <= 1'b0;
            error               <= 1'b0;
            err_code            <= 2'd0;
            for (int i = 0; i < PRL; i++)
                coef_tab[i] <= '0;
        end else begin
            // Out-of-range addresses simply never match an entry.
            for (int i = 0; i < PRL; i++) begin
                if (cfg_wr_en && cfg_open && (int'(cfg_addr) == i))
                    coef_tab[i] <= cfg_data;
            end

            if (abort) begin
                state               <= S_IDLE;
                load_cnt            <= '0;
                wait_cnt            <= '0;
                load_mem            <= 1'b0;
                location            <= '0;
                mem_data            <= '0;
                dfe_signal_in_valid <= 1'b0;
                busy                <= 1'b0;
                running             <= 1'b0;
                error               <= 1'b0;
                err_code            <= 2'd0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (int'(load_cnt) == LOAD_LEN - 1) begin
                            state    <= S_WAIT_DONE;
                            load_cnt <= '0;
                            wait_cnt <= '0;
                            load_mem <= 1'b0;
                            location <= '0;
                            mem_data <= '0;
                        end else begin
                            load_cnt <= next_k;
                            location <= tap_loc(next_k);
                            mem_data <= 64'(next_word);
                        end
                    end

                    S_WAIT_DONE: begin
                        // done_wait is tested first so it wins over a
                        // coincident timeout.
                        if (done_wait) begin
                            state    <= S_RUN;
                            wait_cnt <= '0;
                            busy     <= 1'b0;
                            running  <= 1'b1;
                        end else if (int'(wait_cnt) == DONE_TIMEOUT - 1) begin
                            state    <= S_ERROR;
                            wait_cnt <= '0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= 2'd2;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    default: begin
                        // IDLE, ERROR and RUN all accept start; RUN also
                        // forwards symbols, but a reload kills the valid.
                        dfe_signal_in_valid <= 1'b0;
                        if (state == S_RUN) begin
                            dfe_signal_in       <= sym_in;
                            dfe_signal_in_valid <= sym_in_valid && !start;
                        end
                        if (start) begin
                            running <= 1'b0;
                            if (tap0_ok) begin
                                state    <= S_LOAD;
                                load_cnt <= '0;
                                load_mem <= 1'b1;
                                location <= '0;
                                mem_data <= 64'(coef_tab[0]);
                                busy     <= 1'b1;
                                error    <= 1'b0;
                                err_code <= 2'd0;
                            end else begin
                                state    <= S_ERROR;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                                err_code <= 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dfe_prl_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dfe_prl_ctrl
// Directed bench for dfe_prl_ctrl. A phase/elapsed-time model of the
// controller predicts every output each cycle; a compare process checks the
// DUT against it on every falling edge. The directed sequence additionally
// checks hand-computed literal values at key points.
// -----------------------------------------------------------------------------
module tb_dfe_prl_ctrl;

    localparam int PRL = 5;
    localparam int SR  = 8;
    localparam int PAD = 2;
    localparam int TO  = 64;
    localparam int CW  = 4 * SR;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_wr_en;
    logic [7:0]           cfg_addr;
    logic [CW-1:0]        cfg_data;
    logic                 start;
    logic                 abort;
    logic signed [SR-1:0] sym_in;
    logic                 sym_in_valid;
    logic                 load_mem;
    logic [7:0]           location;
    logic [63:0]          mem_data;
    logic                 done_wait;
    logic signed [SR-1:0] dfe_signal_in;
    logic                 dfe_signal_in_valid;
    logic                 busy;
    logic                 running;
    logic                 error;
    logic [1:0]           err_code;

    dfe_prl_ctrl #(
        .PULSE_RESPONSE_LENGTH(PRL),
        .SIGNAL_RESOLUTION    (SR),
        .LOAD_PAD             (PAD),
        .DONE_TIMEOUT         (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_addr           (cfg_addr),
        .cfg_data           (cfg_data),
        .start              (start),
        .abort              (abort),
        .sym_in             (sym_in),
        .sym_in_valid       (sym_in_valid),
        .load_mem           (load_mem),
        .location           (location),
        .mem_data           (mem_data),
        .done_wait          (done_wait),
        .dfe_signal_in      (dfe_signal_in),
        .dfe_signal_in_valid(dfe_signal_in_valid),
        .busy               (busy),
        .running            (running),
        .error              (error),
        .err_code           (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_WAIT = 2, PH_RUN = 3, PH_ERR = 4;

    int              m_ph;
    int              m_t;      // cycles already spent in the current phase
    bit              m_err;
    int              m_code;
    bit              m_vld;
    logic [SR-1:0]   m_sym;
    logic [CW-1:0]   m_tab [PRL];

    always @(posedge clk) begin
        bit            t0_ok;
        bit            wr;
        bit            nv;
        int            wa;
        logic [CW-1:0] wd;
        if (rst) begin
            m_ph = PH_IDLE; m_t = 0; m_err = 0; m_code = 0; m_vld = 0; m_sym = '0;
            for (int i = 0; i < PRL; i++) m_tab[i] = '0;
        end else begin
            t0_ok = (m_tab[0][31:16] != 16'd0);
            wa    = int'(cfg_addr);
            wd    = cfg_data;
            wr    = cfg_wr_en && (m_ph == PH_IDLE || m_ph == PH_ERR) && wa < PRL;
            nv    = 1'b0;
            if (abort) begin
                m_ph = PH_IDLE; m_t = 0; m_err = 0; m_code = 0;
            end else if (m_ph == PH_LOAD) begin
                if (m_t == PRL + PAD - 1) begin m_ph = PH_WAIT; m_t = 0; end
                else m_t++;
            end else if (m_ph == PH_WAIT) begin
                if (done_wait) begin m_ph = PH_RUN; m_t = 0; end
                else if (m_t == TO - 1) begin m_ph = PH_ERR; m_t = 0; m_err = 1; m_code = 2; end
                else m_t++;
            end else begin
                if (m_ph == PH_RUN) begin
                    m_sym = sym_in;
                    nv    = sym_in_valid && !start;
                end
                if (start) begin
                    if (t0_ok) begin m_ph = PH_LOAD; m_t = 0; m_err = 0; m_code = 0; end
                    else begin m_ph = PH_ERR; m_t = 0; m_err = 1; m_code = 1; end
                end
            end
            m_vld = nv;
            if (wr) m_tab[wa] = wd;
        end
    end

    always @(negedge clk) begin
        int          li;
        bit          ld;
        logic [63:0] ed;
        if (cmp_en) begin
            ld = (m_ph == PH_LOAD);
            li = (m_t < PRL) ? m_t : PRL - 1;
            ed = ld ? 64'(m_tab[li]) : 64'd0;
            chk("m_load_mem", 64'(load_mem), 64'(ld));
            chk("m_location", 64'(location), ld ? 64'(li) : 64'd0);
            chk("m_mem_data", mem_data, ed);
            chk("m_busy", 64'(busy), 64'(m_ph == PH_LOAD || m_ph == PH_WAIT));
            chk("m_running", 64'(running), 64'(m_ph == PH_RUN));
            chk("m_error", 64'(error), 64'(m_err));
            chk("m_err_code", 64'(err_code), 64'(m_code));
            chk("m_sig_valid", 64'(dfe_signal_in_valid), 64'(m_vld));
            if (m_vld)
                chk("m_sig_data", 64'($signed(dfe_signal_in)), 64'($signed(m_sym)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_tab(input int a, input logic [CW-1:0] d);
        cfg_wr_en = 1'b1; cfg_addr = 8'(a); cfg_data = d;
        cyc();
        cfg_wr_en = 1'b0;
    endtask

    logic [CW-1:0] vals [PRL];

    initial begin
        vals[0] = 32'h0003_0002; vals[1] = 32'h0001_0000; vals[2] = 32'h0002_0000;
        vals[3] = 32'hFFFF_0000; vals[4] = 32'h0001_0000;

        rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        abort = 1'b0; sym_in = '0; sym_in_valid = 1'b0; done_wait = 1'b0;
        repeat (3) cyc();
        cmp_en = 1'b1;
        chk("rst_load_mem", 64'(load_mem), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        rst = 1'b0;

        // Load sequence
        for (int i = 0; i < PRL; i++) wr_tab(i, vals[i]);
        start = 1'b1; cyc(); start = 1'b0;
        chk("ld0_load_mem", 64'(load_mem), 64'd1);
        chk("ld0_mem_data", mem_data, 64'h0000_0000_0003_0002);
        chk("ld0_busy", 64'(busy), 64'd1);
        for (int k = 1; k < PRL + PAD; k++) begin
            cyc();
            chk("ld_load_mem", 64'(load_mem), 64'd1);
            chk("ld_location", 64'(location), (k < PRL) ? 64'(k) : 64'd4);
            if (k == 3) chk("ld3_mem_data", mem_data, 64'h0000_0000_FFFF_0000);
            if (k == 4) chk("ld4_mem_data", mem_data, 64'h0000_0000_0001_0000);
        end
        cyc();
        chk("ld_end_load_mem", 64'(load_mem), 64'd0);
        chk("ld_end_busy", 64'(busy), 64'd1);

        // Handshake into RUN
        cyc(); cyc();
        done_wait = 1'b1; cyc(); done_wait = 1'b0;
        chk("run_running", 64'(running), 64'd1);
        chk("run_busy", 64'(busy), 64'd0);
        sym_in = 8'sd28;  sym_in_valid = 1'b1; cyc();
        chk("sym_28", 64'($signed(dfe_signal_in)), 64'(28));
        sym_in = -8'sd28; cyc();
        chk("sym_m28", 64'($signed(dfe_signal_in)), 64'hFFFF_FFFF_FFFF_FFE4);
        sym_in = 8'sd5; sym_in_valid = 1'b0; cyc();
        chk("sym_gap_valid", 64'(dfe_signal_in_valid), 64'd0);
        sym_in = 8'sd84; sym_in_valid = 1'b1; cyc();
        chk("sym_84", 64'($signed(dfe_signal_in)), 64'(84));
        sym_in_valid = 1'b0;
        wr_tab(1, 32'hDEAD_0000);   // ignored while running

        // Reload from RUN
        start = 1'b1; sym_in = 8'sd10; sym_in_valid = 1'b1; cyc();
        start = 1'b0; sym_in_valid = 1'b0;
        chk("reload_valid", 64'(dfe_signal_in_valid), 64'd0);
        chk("reload_load_mem", 64'(load_mem), 64'd1);
        cyc();
        chk("reload_k1_data", mem_data, 64'h0000_0000_0001_0000);
        repeat (PRL + PAD - 1) cyc();

        // Timeout: first WAIT_DONE cycle is visible now
        repeat (TO - 1) cyc();
        chk("to_not_yet", 64'(error), 64'd0);
        cyc();
        chk("to_error", 64'(error), 64'd1);
        chk("to_err_code", 64'(err_code), 64'd2);
        chk("to_load_mem", 64'(load_mem), 64'd0);
        wr_tab(7, 32'h1234_0000);   // out of range, ignored
        done_wait = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        chk("retry_error", 64'(error), 64'd0);
        chk("retry_load_mem", 64'(load_mem), 64'd1);
        repeat (PRL + PAD) cyc();
        cyc();
        chk("retry_running", 64'(running), 64'd1);
        done_wait = 1'b0;

        // Abort with start at LOAD k=2
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        abort = 1'b1; start = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
        chk("abort_load_mem", 64'(load_mem), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        cyc();

        // Zero tap0 mantissa
        wr_tab(0, 32'h0000_0003);
        start = 1'b1; cyc(); start = 1'b0;
        chk("z0_error", 64'(error), 64'd1);
        chk("z0_err_code", 64'(err_code), 64'd1);
        chk("z0_load_mem", 64'(load_mem), 64'd0);
        repeat (3) cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("z0_abort_error", 64'(error), 64'd0);

        // Reset at LOAD k=3 clears the table
        wr_tab(0, 32'h0003_0002);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst2_load_mem", 64'(load_mem), 64'd0);
        chk("rst2_location", 64'(location), 64'd0);
        chk("rst2_mem_data", mem_data, 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        wr_tab(0, 32'h0005_0001);
        start = 1'b1; cyc(); start = 1'b0;
        chk("rl_k0_data", mem_data, 64'h0000_0000_0005_0001);
        cyc();
        chk("rl_k1_data", mem_data, 64'd0);
        cyc(); cyc(); cyc();
        chk("rl_k4_data", mem_data, 64'd0);
        repeat (3) cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
